// File: rtl/predecode_stage_pkg.sv
// Shared widths, opcodes and bus layouts for the pre-decode stage.
// Imported by predecode_stage and its BHT.
package predecode_stage_pkg;

    localparam int FpD_BUS_Wid     = 75;
    localparam int predict_BUS_Wid = 33;
    localparam int pDD_BUS_Wid     = 107;

    localparam int BHT_IDX_HI = 7;
    localparam int BHT_IDX_LO = 2;
    localparam int BHT_IDX_W  = BHT_IDX_HI - BHT_IDX_LO + 1;
    localparam int BHT_DEPTH  = 1 << BHT_IDX_W;
    localparam logic [1:0] BHT_INIT = 2'b01;

    localparam logic [5:0] OP_JIRL = 6'b010011;
    localparam logic [5:0] OP_B    = 6'b010100;
    localparam logic [5:0] OP_BL   = 6'b010101;
    localparam logic [5:0] OP_BEQ  = 6'b010110;
    localparam logic [5:0] OP_BNE  = 6'b010111;
    localparam logic [5:0] OP_BLT  = 6'b011000;
    localparam logic [5:0] OP_BGE  = 6'b011001;
    localparam logic [5:0] OP_BLTU = 6'b011010;
    localparam logic [5:0] OP_BGEU = 6'b011011;

    localparam logic [7:0] ECODE_INT  = 8'h00;
    localparam logic [7:0] ECODE_ADEF = 8'h08;
    localparam logic [7:0] ECODE_ALE  = 8'h09;
    localparam logic [7:0] ECODE_SYS  = 8'h0b;
    localparam logic [7:0] ECODE_BRK  = 8'h0c;
    localparam logic [7:0] ECODE_INE  = 8'h0d;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pc_en;
        logic        ex;
        logic [7:0]  ecode;
        logic        esubcode;
    } fpd_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ex;
        logic [7:0]  ecode;
        logic        esubcode;
    } pd_stage_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic        ex;
        logic [7:0]  ecode;
        logic        esubcode;
    } pdd_bus_t;

    // B/BL carry a 26-bit split offset, conditional branches a 16-bit one
    function automatic logic [31:0] br_offset(
        input logic [31:0] inst,
        input logic        uncond
    );
        logic [31:0] off;
        if (uncond)
            off = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
        else
            off = {{14{inst[25]}}, inst[25:10], 2'b00};
        return off;
    endfunction

endpackage

// File: rtl/predecode_stage_bht.sv
// 2-bit saturating branch history table.
// Async read of the predicting entry; update at the clock edge.
module bht_2bit
    import predecode_stage_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [BHT_IDX_W-1:0] rd_idx_i,
    output logic [1:0]           rd_cnt_o,
    input  logic                 upd_valid_i,
    input  logic [BHT_IDX_W-1:0] upd_idx_i,
    input  logic                 upd_taken_i
);

    logic [1:0] cnt_q [BHT_DEPTH];
    logic [1:0] upd_cur;
    logic [1:0] upd_d;

    assign rd_cnt_o = cnt_q[rd_idx_i];
    assign upd_cur  = cnt_q[upd_idx_i];

    always_comb begin
        upd_d = upd_cur;
        if (upd_taken_i && upd_cur != 2'b11)
            upd_d = upd_cur + 2'd1;
        else if (!upd_taken_i && upd_cur != 2'b00)
            upd_d = upd_cur - 2'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BHT_DEPTH; i++)
                cnt_q[i] <= BHT_INIT;
        end else if (upd_valid_i) begin
            cnt_q[upd_idx_i] <= upd_d;
        end
    end

endmodule

// File: rtl/predecode_stage.sv
// Pre-decode stage: static B/BL and BHT-predicted conditional branches,
// one-shot redirect to Fetch and drop of the wrong-path fetch behind it.
module predecode_stage
    import predecode_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       FpD_valid,
    input  logic [FpD_BUS_Wid-1:0]     FpD_BUS,
    output logic                       pD_allowin,
    output logic [predict_BUS_Wid-1:0] predict_BUS,
    input  logic                       D_allowin,
    output logic                       pDD_valid,
    output logic [pDD_BUS_Wid-1:0]     pDD_BUS,
    input  logic                       predict_error,
    input  logic                       ex_en,
    input  logic                       ertn_flush,
    input  logic                       bht_upd_valid,
    input  logic [31:0]                bht_upd_pc,
    input  logic                       bht_upd_taken
);

    fpd_bus_t  fpd_in;
    pd_stage_t stage_q, stage_d;
    pdd_bus_t  pdd_out;

    logic        valid_q, valid_d;
    logic        wait_q, wait_d;
    logic        sent_q, sent_d;
    logic [31:0] tgt_q, tgt_d;

    logic        flush, drop, accept, pulse;
    logic        uncond, cond, pred_taken;
    logic [5:0]  opcode;
    logic [1:0]  bht_cnt;
    logic [31:0] pred_target;
    logic        unused_bits;

    assign fpd_in = fpd_bus_t'(FpD_BUS);
    assign unused_bits = ^{fpd_in.pc_en, bht_cnt[0],
                           bht_upd_pc[31:8], bht_upd_pc[1:0]};

    assign flush      = predict_error | ex_en | ertn_flush;
    assign drop       = wait_q & (fpd_in.pc != tgt_q);
    assign pD_allowin = !valid_q | D_allowin;
    assign accept     = FpD_valid & pD_allowin & !flush & !drop;
    assign pDD_valid  = valid_q & !flush;

    bht_2bit u_bht (
        .clk_i       (clk),
        .rst_i       (rst),
        .rd_idx_i    (stage_q.pc[BHT_IDX_HI:BHT_IDX_LO]),
        .rd_cnt_o    (bht_cnt),
        .upd_valid_i (bht_upd_valid),
        .upd_idx_i   (bht_upd_pc[BHT_IDX_HI:BHT_IDX_LO]),
        .upd_taken_i (bht_upd_taken)
    );

    assign opcode = stage_q.inst[31:26];

    always_comb begin
        uncond = 1'b0;
        cond   = 1'b0;
        unique case (1'b1)
            (opcode == OP_B) || (opcode == OP_BL):
                uncond = 1'b1;
            (opcode >= OP_BEQ) && (opcode <= OP_BGEU):
                cond = 1'b1;
            default: ;
        endcase
    end

    assign pred_taken  = !stage_q.ex & (uncond | (cond & bht_cnt[1]));
    assign pred_target = pred_taken
                       ? stage_q.pc + br_offset(stage_q.inst, uncond)
                       : 32'h0;

    // Redirect only in the first cycle an instruction sits in pD
    assign pulse       = valid_q & pred_taken & !sent_q & !flush;
    assign predict_BUS = {pulse, valid_q ? pred_target : 32'h0};

    assign pdd_out = '{
        pc:          stage_q.pc,
        inst:        stage_q.inst,
        pred_taken:  pred_taken,
        pred_target: pred_target,
        ex:          stage_q.ex,
        ecode:       stage_q.ecode,
        esubcode:    stage_q.esubcode
    };
    assign pDD_BUS = pdd_out;

    always_comb begin
        valid_d = valid_q;
        wait_d  = wait_q;
        sent_d  = sent_q;
        tgt_d   = tgt_q;
        stage_d = stage_q;
        if (flush) begin
            valid_d = 1'b0;
            wait_d  = 1'b0;
            sent_d  = 1'b0;
        end else begin
            if (accept) begin
                valid_d = 1'b1;
                sent_d  = 1'b0;
                stage_d = '{fpd_in.pc, fpd_in.inst, fpd_in.ex,
                            fpd_in.ecode, fpd_in.esubcode};
            end else begin
                if (D_allowin)
                    valid_d = 1'b0;
                if (pulse)
                    sent_d = 1'b1;
            end
            if (pulse) begin
                wait_d = 1'b1;
                tgt_d  = pred_target;
            end else if (accept) begin
                wait_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            wait_q  <= 1'b0;
            sent_q  <= 1'b0;
            tgt_q   <= '0;
            stage_q <= '0;
        end else begin
            valid_q <= valid_d;
            wait_q  <= wait_d;
            sent_q  <= sent_d;
            tgt_q   <= tgt_d;
            stage_q <= stage_d;
        end
    end

endmodule
